// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq: iterative signed fixed-point divider (restoring, one bit per cycle).
//
// Computes out = (in_0 << FRAC_BITS) / in_1 in the same Q-format the
// multipliers produce. Truncates toward zero and saturates to the WIDTH-bit
// signed range. Only one operation is in flight at a time.
//
// Optional feature: define APPROX_DIV_EN to skip the last APPR_BITS quotient
// iterations. Those low quotient bits are then forced to zero, and latency
// drops by APPR_BITS cycles.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; aborts any operation
//   in_valid     operand pair valid
//   in_ready     divider idle and able to accept operands
//   in_0         dividend, signed
//   in_1         divisor, signed
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts result
//   out          quotient, signed, saturated
//   div_by_zero  result came from a zero divisor
//   ovf          result was saturated due to overflow
// ----------------------------------------------------------------------------
module div_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned APPR_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             div_by_zero,
    output logic             ovf
);

`ifdef APPROX_DIV_EN
    localparam bit ApproxEn = 1'b1;
`else
    localparam bit ApproxEn = 1'b0;
`endif

    localparam int unsigned N     = WIDTH + FRAC_BITS;
    localparam int unsigned Skip  = ApproxEn ? APPR_BITS : 0;
    localparam int unsigned Iters = N - Skip;
    localparam int unsigned CntW  = $clog2(N + 1);

    // Largest magnitudes representable for positive / negative results.
    localparam logic [N-1:0] PosMag = {{(FRAC_BITS + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [N-1:0] NegMag = PosMag + 1'b1;
    localparam logic [WIDTH-1:0] PosSat = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] NegSat = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [N-1:0]      num_q;
    logic [WIDTH-1:0]  rem_q;
    logic [N-2:0]      quo_q;
    logic [WIDTH-1:0]  div_q;
    logic              sign_q;
    logic [WIDTH-1:0]  out_q;
    logic              dbz_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  abs_0, abs_1;
    logic [WIDTH:0]    rem_sh, trial;
    logic              q_bit;
    logic [WIDTH-1:0]  rem_nx;
    logic [N-1:0]      quo_nx, mag;
    logic [WIDTH-1:0]  res;
    logic              res_ovf;
    logic              last_step;

    // Magnitudes; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned value.
    assign abs_0 = in_0[WIDTH-1] ? -in_0 : in_0;
    assign abs_1 = in_1[WIDTH-1] ? -in_1 : in_1;

    // One restoring step; remainder always stays below the divisor so WIDTH bits suffice.
    assign rem_sh    = {rem_q, num_q[N-1]};
    assign trial     = rem_sh - {1'b0, div_q};
    assign q_bit     = ~trial[WIDTH];
    assign rem_nx    = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx    = {quo_q, q_bit};
    assign mag       = quo_nx << Skip;
    assign last_step = (cnt_q == CntW'(1));

    // Sign fix and saturation of the final magnitude.
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        if (!sign_q) begin
            if (mag > PosMag) begin
                res     = PosSat;
                res_ovf = 1'b1;
            end else begin
                res = mag[WIDTH-1:0];
            end
        end else begin
            if (mag > NegMag) begin
                res     = NegSat;
                res_ovf = 1'b1;
            end else begin
                res = -mag[WIDTH-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = (in_1 == '0) ? StDone : StCalc;
            StCalc: if (last_step) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        in_ready    = (state_q == StIdle) && !rst;
        out_valid   = (state_q == StDone);
        out         = out_q;
        div_by_zero = dbz_q;
        ovf         = ovf_q;
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            num_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            sign_q <= 1'b0;
            out_q  <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q <= in_0[WIDTH-1] ^ in_1[WIDTH-1];
                        div_q  <= abs_1;
                        num_q  <= N'(abs_0) << FRAC_BITS;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        cnt_q  <= CntW'(Iters);
                        ovf_q  <= 1'b0;
                        dbz_q  <= (in_1 == '0);
                        if (in_1 == '0) begin
                            out_q <= in_0[WIDTH-1] ? NegSat : PosSat;
                        end
                    end
                end
                StCalc: begin
                    num_q <= {num_q[N-2:0], 1'b0};
                    rem_q <= rem_nx;
                    quo_q <= quo_nx[N-2:0];
                    cnt_q <= cnt_q - CntW'(1);
                    if (last_step) begin
                        out_q <= res;
                        ovf_q <= res_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// ----------------------------------------------------------------------------
// tb_div_seq: directed self-checking bench for div_seq (WIDTH=32, FRAC_BITS=8).
// Expected values are hand-computed; APPROX_DIV_EN selects the approximate set.
// ----------------------------------------------------------------------------
module tb_div_seq;

`ifdef APPROX_DIV_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 41;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_0 = '0;
    logic [31:0] in_1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        div_by_zero;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_seq #(
        .WIDTH    (32),
        .FRAC_BITS(8),
        .APPR_BITS(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_0       (in_0),
        .in_1       (in_1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .div_by_zero(div_by_zero),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present operands for the accepting edge, then wait for out_valid.
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_0     = a;
        in_1     = b;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic exp_dbz, input logic exp_ovf,
                          input int exp_lat);
        int lat;
        start_op(tag, a, b, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
        release_out();
        check({tag, "_idle"}, {30'b0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int lat;
        logic        stable;
        logic [31:0] held;

        // Reset state.
        rst = 1'b1;
        tick();
        check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_out", out, 32'h0);
        check("rst_flags", {29'b0, out_valid, div_by_zero, ovf}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset mid-CALC: accept, reset on cycle 10, result must never appear.
        in_valid = 1'b1;
        in_0 = 32'h300;
        in_1 = 32'h200;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        #1;
        check("abort_in_ready_low", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_flags", {29'b0, out_valid, div_by_zero, ovf}, 32'd0);
        check("abort_out", out, 32'h0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (45) begin
            tick();
            if (out_valid) check("abort_no_result", {31'b0, out_valid}, 32'd0);
        end

`ifdef APPROX_DIV_EN
        run_op("again",  32'h300,        32'h200, 32'h00000100, 1'b0, 1'b0, LAT);
        run_op("basic",  32'h300,        32'h200, 32'h00000100, 1'b0, 1'b0, LAT);
        run_op("neg",    -32'sh300,      32'h200, 32'hFFFFFF00, 1'b0, 1'b0, LAT);
        run_op("third",  32'h100,        32'h300, 32'h00000000, 1'b0, 1'b0, LAT);
        run_op("nthird", -32'sh100,      32'h300, 32'h00000000, 1'b0, 1'b0, LAT);
`else
        run_op("again",  32'h300,        32'h200, 32'h00000180, 1'b0, 1'b0, LAT);
        run_op("basic",  32'h300,        32'h200, 32'h00000180, 1'b0, 1'b0, LAT);
        run_op("neg",    -32'sh300,      32'h200, 32'hFFFFFE80, 1'b0, 1'b0, LAT);
        run_op("third",  32'h100,        32'h300, 32'h00000055, 1'b0, 1'b0, LAT);
        run_op("nthird", -32'sh100,      32'h300, 32'hFFFFFFAB, 1'b0, 1'b0, LAT);
`endif
        run_op("negdiv", 32'h300,        -32'sh200, (LAT == 41) ? 32'hFFFFFE80 : 32'hFFFFFF00,
               1'b0, 1'b0, LAT);
        run_op("zero_n", 32'h0,          32'h123,   32'h0,        1'b0, 1'b0, LAT);

        // Divide by zero.
        run_op("dbz_pos", 32'h100,       32'h0,     32'h7FFFFFFF, 1'b1, 1'b0, 1);
        run_op("dbz_neg", 32'hFFFFFFFF,  32'h0,     32'h80000000, 1'b1, 1'b0, 1);
        run_op("dbz_zero", 32'h0,        32'h0,     32'h7FFFFFFF, 1'b1, 1'b0, 1);

        // Overflow / saturation boundaries.
        run_op("ovf_pos", 32'h7FFFFFFF,  32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, LAT);
        run_op("min_ex",  32'h80000000,  32'h100,      32'h80000000, 1'b0, 1'b0, LAT);
        run_op("ovf_mm",  32'h80000000,  32'hFFFFFF00, 32'h7FFFFFFF, 1'b0, 1'b1, LAT);
        run_op("ovf_neg", 32'h80000000,  32'h80,       32'h80000000, 1'b0, 1'b1, LAT);

        // Backpressure: result held, in_valid ignored, single handshake on release.
        start_op("bp", 32'h300, 32'h200, lat);
        check("bp_lat", lat, LAT);
        held   = out;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                in_0 = 32'h100;
                in_1 = 32'h0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out !== held || !out_valid || in_ready || div_by_zero || ovf) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", {31'b0, stable}, 32'd1);
        check("bp_out", out, (LAT == 41) ? 32'h00000180 : 32'h00000100);
        release_out();
        check("bp_release", {30'b0, in_ready, out_valid}, 32'b10);
        tick();
        check("bp_single", {30'b0, in_ready, out_valid}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative signed fixed-point divider; the arithmetic inverse of the mul_0/mul_1 multiplier family.
- Computes quotient = (dividend << FRAC_BITS) / divisor in the same Q-format that the multipliers produce with `SHIFT_WIDTH`.
- Used as a schedulable multi-cycle DFG resource alongside the add_*/mul_* units.
- Valid/ready handshakes on both sides, one operation in flight at a time.

Parameters:
- WIDTH, 32, operand and result width (two's complement).
- FRAC_BITS, 8, fractional bits; instantiations pass `SHIFT_WIDTH.
- APPR_BITS, 8, number of quotient LSB iterations skipped when APPROX_DIV_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept operands.
- in_0  input  WIDTH  dividend, signed.
- in_1  input  WIDTH  divisor, signed.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  quotient, signed, saturated.
- div_by_zero  output  1  result came from divisor == 0; valid with out_valid.
- ovf  output  1  result was saturated due to overflow; valid with out_valid.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state=IDLE;
  - out, div_by_zero, ovf, out_valid all 0;
  - counter and shift registers cleared;
  - in_ready=0 while rst is high.
  - rst mid-CALC or in DONE aborts the operation; the result is discarded and never presented.
- States:
  - IDLE: in_ready=1. in_valid&in_ready latches the operands, records sign = in_0[MSB]^in_1[MSB], and converts both operands to unsigned magnitudes (WIDTH bits; |-2^(WIDTH-1)| is representable). Next state is CALC with count N = WIDTH+FRAC_BITS. If in_1==0, next state is DONE directly.
  - CALC: in_ready=0. Each cycle performs one restoring step on the (WIDTH+FRAC_BITS)-bit numerator = |in_0|<<FRAC_BITS: shift the partial remainder left, bring in the next numerator bit, trial-subtract |divisor|, and shift in the quotient bit. Count decrements each cycle. When count reaches 1, sign fix and saturation are registered and the next state is DONE.
  - DONE: out_valid=1. out, div_by_zero and ovf hold stable until out_valid&out_ready, then the next state is IDLE. in_ready rises the cycle after the handshake; back-to-back issue is not supported.
- Latency:
  - out_valid is asserted N+1 cycles after the accepting edge (41 cycles at defaults).
  - Divide-by-zero: asserted 1 cycle after the accepting edge.
- Rounding: truncation toward zero; the sign is applied to the magnitude quotient Q.
- Saturation:
  - Positive result with Q > 2^(WIDTH-1)-1: out = 0x7FFFFFFF, ovf=1.
  - Negative result with Q > 2^(WIDTH-1): out = 0x80000000, ovf=1.
  - Q == 2^(WIDTH-1) with a negative result is exact: out = 0x80000000, ovf=0.
- Divide-by-zero:
  - in_0 >= 0 gives out = 0x7FFFFFFF; in_0 < 0 gives out = 0x80000000.
  - div_by_zero=1, ovf=0.
- Zero dividend with nonzero divisor: out = 0, no flags.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Optional Feature:
- Macro APPROX_DIV_EN.
- Defined:
  - CALC runs N-APPR_BITS iterations.
  - The quotient's low APPR_BITS bits are forced to 0 before sign fix; negation applies to the truncated magnitude.
  - Latency becomes N-APPR_BITS+1 cycles (33 at defaults).
  - Saturation rules are unchanged.
- Undefined: exact behaviour and latency as above; APPR_BITS is unused.

Test Plan:
- Reset mid-CALC: accept 0x300/0x200, assert rst at cycle 10 for 1 cycle. Required: out_valid=0, out=0, flags 0; in_ready=1 the cycle after rst drops. A new 0x300/0x200 then returns 0x00000180.
- Basic and sign, defaults:
  - 0x300/0x200 gives out 0x00000180, out_valid exactly 41 cycles after accept.
  - -0x300/0x200 gives 0xFFFFFE80.
  - 0x100/0x300 gives 0x00000055.
  - -0x100/0x300 gives 0xFFFFFFAB.
- Divide-by-zero:
  - 0x100/0 gives 0x7FFFFFFF, div_by_zero=1, latency 1.
  - -1/0 gives 0x80000000.
  - 0/0 gives 0x7FFFFFFF.
- Overflow:
  - 0x7FFFFFFF/0x1 gives 0x7FFFFFFF, ovf=1.
  - 0x80000000/0x100 gives 0x80000000, ovf=0.
  - 0x80000000/0xFFFFFF00 gives 0x7FFFFFFF, ovf=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: out and flags stable, in_ready=0, a concurrent in_valid pulse is ignored. Releasing out_ready gives exactly one handshake, then in_ready=1 on the next cycle.
- APPROX_DIV_EN defined (APPR_BITS=8):
  - 0x300/0x200 gives 0x00000100 with latency 33.
  - 0x100/0x300 gives 0x00000000.
  - -0x300/0x200 gives 0xFFFFFF00.
